// File: rtl/bmem_arb_pkg.sv
// Shared types and widths for the bmem arbiter.
//   arb_owner_t : which requester owns an outstanding read
//   arb_state_t : issue FSM state
//   arb_tag_t   : outstanding-read queue entry {owner, line address}
package bmem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned LINE_W = 256;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_state_t;

  typedef struct packed {
    arb_owner_t        owner;
    logic [ADDR_W-1:0] addr;
  } arb_tag_t;

endpackage

// File: rtl/bmem_arbiter_if.sv
// Bus bundle between the requesters (icache fill, dcache), the arbiter and bmem.
//   slave  : arbiter view (takes requests and bmem returns, drives grants/beats/commands)
//   master : environment view (requesters plus bmem model)
interface bmem_arbiter_if;
  import bmem_arb_pkg::*;

  // icache requester
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic              i_ready;
  logic              i_rvalid;
  logic [BEAT_W-1:0] i_rdata;
  logic [ADDR_W-1:0] i_raddr;
  // dcache requester
  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [BEAT_W-1:0] d_rdata;
  logic [ADDR_W-1:0] d_raddr;
  logic              d_wdone;
  // bmem burst port
  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport slave (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
           bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output i_ready, i_rvalid, i_rdata, i_raddr,
           d_ready, d_rvalid, d_rdata, d_raddr, d_wdone,
           bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport master (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
           bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  i_ready, i_rvalid, i_rdata, i_raddr,
           d_ready, d_rvalid, d_rdata, d_raddr, d_wdone,
           bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

endinterface

// File: rtl/arb_tag_fifo.sv
// In-order queue of outstanding read tags.
//   clk, rst_n : clock, synchronous active-low reset
//   i_push/i_data : enqueue (ignored when full)
//   i_pop         : dequeue head (ignored when empty)
//   o_full/o_empty/o_head : status and head entry
module arb_tag_fifo
  import bmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  arb_tag_t i_data,
  input  logic     i_pop,
  output logic     o_full,
  output logic     o_empty,
  output arb_tag_t o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  arb_tag_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bmem_arbiter.sv
// Shares the bmem burst port between icache-fill and dcache requesters.
// Issues read commands and 4-beat write bursts, tracks outstanding reads
// in order and steers returning beats to the owning requester.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : bmem_arbiter_if.slave (requester handshakes, bmem port)
//   err        : sticky protocol error (return with empty queue, or
//                first-beat address not matching the queue head)
// Optional: define BMEM_ARB_AGING_EN to let a starved icache request
// override dcache priority after AGE_LIMIT passed-over cycles.
module bmem_arbiter
  import bmem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned BURST_BEATS     = 4
`ifdef BMEM_ARB_AGING_EN
  , parameter int unsigned AGE_LIMIT     = 8
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  bmem_arbiter_if.slave  bus,
  output logic           err
);

  localparam int unsigned BEAT_CNT_W = $clog2(BURST_BEATS);
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BURST_BEATS - 1);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [BEAT_CNT_W-1:0]  r_wbeat;
  logic [BEAT_CNT_W-1:0]  w_wbeat_nxt;
  logic [BEAT_CNT_W-1:0]  r_rbeat;
  logic [ADDR_W-1:0]      r_waddr;
  logic [LINE_W-1:0]      r_wline;
  logic                   r_wdone;
  logic                   r_err;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  arb_tag_t               w_push_tag;
  arb_tag_t               w_head;
  logic                   w_d_elig;
  logic                   w_i_elig;
  logic                   w_i_first;
  logic                   w_wr_start;
  logic                   w_wdone_nxt;
  logic                   w_ret;
  logic                   w_err_set;

  arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_tag),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifdef BMEM_ARB_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] r_age;

  // Cycles a pending icache request has been passed over (saturating)
  always_ff @(posedge clk) begin
    if (!rst_n)                          r_age <= '0;
    else if (bus.i_ready)                r_age <= '0;
    else if (bus.i_read && r_age != '1)  r_age <= r_age + AGE_W'(1);
  end

  assign w_i_first = (r_age >= AGE_W'(AGE_LIMIT));
`else
  assign w_i_first = 1'b0;
`endif

  // Issue FSM: grant selection, command/beat drive, next state
  always_comb begin
    w_state_nxt    = r_state;
    w_wbeat_nxt    = r_wbeat;
    w_push         = 1'b0;
    w_push_tag     = '{owner: OWN_I, addr: '0};
    w_wr_start     = 1'b0;
    w_wdone_nxt    = 1'b0;
    bus.i_ready    = 1'b0;
    bus.d_ready    = 1'b0;
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_addr  = '0;
    bus.bmem_wdata = '0;
    // Reads need a free tag slot; writes carry no tag
    w_d_elig = (bus.d_read && !w_full) || bus.d_write;
    w_i_elig = bus.i_read && !w_full;

    if (rst_n) begin
      case (r_state)
        ARB_IDLE: begin
          if (w_d_elig && !(w_i_first && w_i_elig)) begin
            bus.bmem_addr = bus.d_addr;
            if (bus.d_write) begin
              // Beat 0 goes straight from the request; the line is latched on accept
              bus.bmem_write = 1'b1;
              bus.bmem_wdata = bus.d_wdata[BEAT_W-1:0];
              if (bus.bmem_ready) begin
                bus.d_ready = 1'b1;
                w_wr_start  = 1'b1;
                w_state_nxt = ARB_WRITE;
                w_wbeat_nxt = BEAT_CNT_W'(1);
              end
            end else begin
              bus.bmem_read = 1'b1;
              if (bus.bmem_ready) begin
                bus.d_ready = 1'b1;
                w_push      = 1'b1;
                w_push_tag  = '{owner: OWN_D, addr: bus.d_addr};
              end
            end
          end else if (w_i_elig) begin
            bus.bmem_addr = bus.i_addr;
            bus.bmem_read = 1'b1;
            if (bus.bmem_ready) begin
              bus.i_ready = 1'b1;
              w_push      = 1'b1;
              w_push_tag  = '{owner: OWN_I, addr: bus.i_addr};
            end
          end
        end
        ARB_WRITE: begin
          bus.bmem_write = 1'b1;
          bus.bmem_addr  = r_waddr;
          bus.bmem_wdata = r_wline[r_wbeat*BEAT_W +: BEAT_W];
          if (bus.bmem_ready) begin
            if (r_wbeat == LAST_BEAT) begin
              w_state_nxt = ARB_IDLE;
              w_wbeat_nxt = '0;
              w_wdone_nxt = 1'b1;
            end else begin
              w_wbeat_nxt = r_wbeat + BEAT_CNT_W'(1);
            end
          end
        end
        default: w_state_nxt = ARB_IDLE;
      endcase
    end
  end

  // Return path: route each beat to the owner at the queue head
  always_comb begin
    bus.i_rvalid = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rdata  = '0;
    bus.i_raddr  = '0;
    bus.d_raddr  = '0;
    w_pop        = 1'b0;
    w_ret        = rst_n && bus.bmem_rvalid && !w_empty;
    // Address is only checked on the first beat; later beats follow the head
    w_err_set    = rst_n && bus.bmem_rvalid &&
                   (w_empty || ((r_rbeat == '0) && (bus.bmem_raddr != w_head.addr)));
    if (w_ret) begin
      w_pop = (r_rbeat == LAST_BEAT);
      if (w_head.owner == OWN_D) begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = bus.bmem_rdata;
        bus.d_raddr  = bus.bmem_raddr;
      end else begin
        bus.i_rvalid = 1'b1;
        bus.i_rdata  = bus.bmem_rdata;
        bus.i_raddr  = bus.bmem_raddr;
      end
    end
  end

  // State, beat counters, write line latch, sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_wbeat <= '0;
      r_rbeat <= '0;
      r_waddr <= '0;
      r_wline <= '0;
      r_wdone <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wbeat <= w_wbeat_nxt;
      r_wdone <= w_wdone_nxt;
      if (w_err_set) r_err <= 1'b1;
      if (w_ret)     r_rbeat <= w_pop ? '0 : r_rbeat + BEAT_CNT_W'(1);
      if (w_wr_start) begin
        r_waddr <= bus.d_addr;
        r_wline <= bus.d_wdata;
      end
    end
  end

  assign bus.d_wdone = r_wdone;
  assign err         = r_err;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Bench for bmem_arbiter: directed scenarios plus randomized traffic, each
// cycle compared against a transaction-level model (tag queue, write burst
// progress, return beat count) built from the arbitration rules.
module tb_bmem_arbiter;

  localparam int MAXO = 4;
`ifdef BMEM_ARB_AGING_EN
  localparam int AGE_LIMIT = 8;
  int m_age = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic err;

  bmem_arbiter_if bif();

  bmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        own_d;
    logic [31:0] addr;
  } tb_tag_t;

  tb_tag_t      mq[$];
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  bit           m_wbusy = 0, m_wdone = 0, m_err = 0;
  int           m_wbeat = 0, m_rbeat = 0;
  logic [31:0]  m_waddr = '0;
  logic [255:0] m_wline = '0;
  bit           last_ir = 0, last_dr = 0;
  bit           obs_ir = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check one cycle against the model, advance the model, move to next negedge
  task automatic cyc();
    bit ir, dr, br, bw, iv, dv, i_elig, d_elig, i_first;
    logic [31:0] ba;
    logic [63:0] bd;
    int occ;
    tb_tag_t hd, t;
    #1;
    occ = mq.size();
    ir = 0; dr = 0; br = 0; bw = 0; iv = 0; dv = 0; i_first = 0;
    ba = '0; bd = '0;
    hd = (occ > 0) ? mq[0] : '0;
    if (rst_n) begin
      if (m_wbusy) begin
        bw = 1; ba = m_waddr; bd = m_wline[64*m_wbeat +: 64];
      end else begin
        d_elig = (bif.d_read && occ < MAXO) || bif.d_write;
        i_elig = bif.i_read && occ < MAXO;
`ifdef BMEM_ARB_AGING_EN
        i_first = i_elig && (m_age >= AGE_LIMIT);
`endif
        if (d_elig && !i_first) begin
          ba = bif.d_addr;
          if (bif.d_write) begin bw = 1; bd = bif.d_wdata[63:0]; end
          else br = 1;
          dr = bif.bmem_ready;
        end else if (i_elig) begin
          ba = bif.i_addr; br = 1; ir = bif.bmem_ready;
        end
      end
      if (bif.bmem_rvalid && occ > 0) begin iv = !hd.own_d; dv = hd.own_d; end
    end
    obs_ir = bif.i_ready;
    check_eq("i_ready",    64'(bif.i_ready),    64'(ir));
    check_eq("d_ready",    64'(bif.d_ready),    64'(dr));
    check_eq("bmem_read",  64'(bif.bmem_read),  64'(br));
    check_eq("bmem_write", 64'(bif.bmem_write), 64'(bw));
    if (br || bw || !rst_n) check_eq("bmem_addr", 64'(bif.bmem_addr), 64'(ba));
    if (bw || !rst_n)       check_eq("bmem_wdata", bif.bmem_wdata, bd);
    check_eq("i_rvalid", 64'(bif.i_rvalid), 64'(iv));
    check_eq("d_rvalid", 64'(bif.d_rvalid), 64'(dv));
    if (iv || !rst_n) begin
      check_eq("i_rdata", bif.i_rdata, iv ? bif.bmem_rdata : 64'h0);
      check_eq("i_raddr", 64'(bif.i_raddr), iv ? 64'(bif.bmem_raddr) : 64'h0);
    end
    if (dv || !rst_n) begin
      check_eq("d_rdata", bif.d_rdata, dv ? bif.bmem_rdata : 64'h0);
      check_eq("d_raddr", 64'(bif.d_raddr), dv ? 64'(bif.bmem_raddr) : 64'h0);
    end
    check_eq("d_wdone", 64'(bif.d_wdone), 64'(m_wdone));
    check_eq("err",     64'(err),         64'(m_err));

    if (!rst_n) begin
      mq.delete();
      m_wbusy = 0; m_wbeat = 0; m_rbeat = 0; m_wdone = 0; m_err = 0;
`ifdef BMEM_ARB_AGING_EN
      m_age = 0;
`endif
    end else begin
      m_wdone = 0;
      if (m_wbusy) begin
        if (bif.bmem_ready) begin
          if (m_wbeat == 3) begin m_wbusy = 0; m_wdone = 1; end
          else m_wbeat++;
        end
      end else if (dr && bif.d_write) begin
        m_wbusy = 1; m_wbeat = 1; m_waddr = bif.d_addr; m_wline = bif.d_wdata;
      end
      if (bif.bmem_rvalid) begin
        if (occ == 0) m_err = 1;
        else begin
          if (m_rbeat == 0 && bif.bmem_raddr != hd.addr) m_err = 1;
          if (m_rbeat == 3) begin mq.delete(0); m_rbeat = 0; end
          else m_rbeat++;
        end
      end
      if (ir) begin t.own_d = 1'b0; t.addr = bif.i_addr; mq.push_back(t); end
      if (dr && bif.d_read) begin t.own_d = 1'b1; t.addr = bif.d_addr; mq.push_back(t); end
`ifdef BMEM_ARB_AGING_EN
      if (ir) m_age = 0;
      else if (bif.i_read && m_age < AGE_LIMIT) m_age++;
`endif
    end
    last_ir = ir;
    last_dr = dr;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bif.i_read = 0; bif.i_addr = '0;
    bif.d_read = 0; bif.d_write = 0; bif.d_addr = '0; bif.d_wdata = '0;
    bif.bmem_ready = 1; bif.bmem_rvalid = 0; bif.bmem_raddr = '0; bif.bmem_rdata = '0;
  endtask

  // Return well-formed beats for outstanding reads (bounded)
  task automatic drain(input int bound);
    int n = 0;
    while (mq.size() > 0 && n < bound) begin
      bif.bmem_rvalid = 1; bif.bmem_raddr = mq[0].addr;
      bif.bmem_rdata = {$urandom, $urandom};
      cyc(); n++;
    end
    bif.bmem_rvalid = 0;
  endtask

  task automatic wait_i(input int bound);
    int n = 0;
    while (!last_ir && n < bound) begin cyc(); n++; end
    check_eq("i_grant_wait", 64'(obs_ir), 64'(1));
  endtask

  initial begin
    int k;
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    cyc(); cyc();
    rst_n = 1;
    cyc();

    // icache read, four beats back
    bif.i_read = 1; bif.i_addr = 32'h0000_1000;
    cyc();
    bif.i_read = 0;
    for (int b = 0; b < 4; b++) begin
      bif.bmem_rvalid = 1; bif.bmem_raddr = 32'h0000_1000;
      bif.bmem_rdata = 64'(8'h11 * (b + 1));
      cyc();
    end
    bif.bmem_rvalid = 0;
    cyc();

    // Simultaneous reads: dcache first, icache next cycle
    bif.i_read = 1; bif.i_addr = 32'h0000_3000;
    bif.d_read = 1; bif.d_addr = 32'h0000_4000;
    cyc();
    bif.d_read = 0;
    wait_i(4);
    bif.i_read = 0;
    drain(20);

    // Write burst with stalled beat 2; icache read held meanwhile
    bif.d_write = 1; bif.d_addr = 32'h0000_2000;
    bif.d_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    cyc();
    bif.d_write = 0; bif.i_read = 1; bif.i_addr = 32'h0000_5000;
    cyc();
    bif.bmem_ready = 0;
    cyc(); cyc(); cyc();
    bif.bmem_ready = 1;
    cyc(); cyc();
    wait_i(4);
    bif.i_read = 0;
    drain(20);

    // Fill the queue, confirm reads blocked but a write still accepted
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0) begin bif.d_read = 1; bif.d_addr = 32'h0000_6000 + 32'(r * 32); end
      else begin bif.i_read = 1; bif.i_addr = 32'h0000_6000 + 32'(r * 32); end
      cyc();
      bif.d_read = 0; bif.i_read = 0;
    end
    bif.i_read = 1; bif.i_addr = 32'h0000_7000;
    cyc(); cyc(); cyc();
    bif.d_write = 1; bif.d_addr = 32'h0000_8000;
    bif.d_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    cyc();
    bif.d_write = 0;
    cyc(); cyc(); cyc(); cyc();
    for (int b = 0; b < 4; b++) begin
      bif.bmem_rvalid = 1; bif.bmem_raddr = mq.size() > 0 ? mq[0].addr : 32'h0;
      bif.bmem_rdata = {$urandom, $urandom};
      cyc();
    end
    bif.bmem_rvalid = 0;
    wait_i(4);
    bif.i_read = 0;
    drain(40);

    // Protocol errors, sticky until reset; reset mid-burst with a read outstanding
    bif.bmem_rvalid = 1; bif.bmem_raddr = 32'h0000_1234; bif.bmem_rdata = 64'h5;
    cyc();
    bif.bmem_rvalid = 0;
    cyc();
    bif.d_read = 1; bif.d_addr = 32'h0000_9000;
    cyc();
    bif.d_read = 0;
    bif.bmem_rvalid = 1; bif.bmem_raddr = 32'h0000_9020;
    cyc();
    bif.bmem_raddr = 32'h0000_9000;
    cyc(); cyc(); cyc();
    bif.bmem_rvalid = 0;
    cyc();
    bif.d_read = 1; bif.d_addr = 32'h0000_A000;
    cyc();
    bif.d_read = 0; bif.d_write = 1; bif.d_addr = 32'h0000_A100;
    cyc();
    bif.d_write = 0;
    cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    cyc();
    bif.bmem_rvalid = 1; bif.bmem_raddr = 32'h0000_A000;
    cyc();
    bif.bmem_rvalid = 0;
    cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    cyc();

`ifdef BMEM_ARB_AGING_EN
    // Starved icache request wins once aged
    begin
      int n = 0;
      bif.i_read = 1; bif.i_addr = 32'h0000_B000;
      bif.d_read = 1; bif.d_addr = 32'h0001_0000;
      while (!last_ir && n < 60) begin
        if (last_dr) bif.d_addr = bif.d_addr + 32'h20;
        bif.bmem_rvalid = (mq.size() > 0);
        bif.bmem_raddr = mq.size() > 0 ? mq[0].addr : 32'h0;
        bif.bmem_rdata = {$urandom, $urandom};
        cyc(); n++;
      end
      check_eq("aged_i_grant", 64'(obs_ir), 64'(1));
      bif.i_read = 0; bif.d_read = 0;
      drain(80);
    end
`endif

    // Randomized traffic; requests held until accepted
    for (int c = 0; c < 3000; c++) begin
      if (!bif.i_read || last_ir) begin
        bif.i_read = ($urandom_range(0, 2) == 0);
        bif.i_addr = $urandom & 32'hFFFF_FFE0;
      end
      if (!(bif.d_read || bif.d_write) || last_dr) begin
        k = $urandom_range(0, 3);
        bif.d_read  = (k == 1);
        bif.d_write = (k == 2);
        bif.d_addr  = $urandom & 32'hFFFF_FFE0;
        bif.d_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      bif.bmem_ready = ($urandom_range(0, 3) != 0);
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
        bif.bmem_rvalid = 1; bif.bmem_raddr = mq[0].addr;
      end else begin
        bif.bmem_rvalid = 0; bif.bmem_raddr = $urandom;
      end
      bif.bmem_rdata = {$urandom, $urandom};
      cyc();
    end
    bif.i_read = 0; bif.d_read = 0; bif.d_write = 0; bif.bmem_ready = 1;
    cyc(); cyc(); cyc(); cyc(); cyc();
    drain(40);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bmem_arbiter.md
Name: bmem_arbiter

Overview:
- Shares the single bmem burst port between the icache-fill requester and the dcache requester.
- Issues read commands and 4-beat write bursts.
- Tracks outstanding reads in an in-order tag queue and steers returning 64-bit beats to the owning requester.
- Sits between the cacheline adapter / prefetch logic and the bmem model; replaces ad-hoc address-matching of read returns.

Parameters:
- MAX_OUTSTANDING, 4, depth of outstanding-read queue (power of 2, ≥2).
- BURST_BEATS, 4, 64-bit beats per 256-bit line.
- AGE_LIMIT, 8, cycles an icache request may be passed over before forced grant (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_addr  in  32  icache line address.
- i_read  in  1  icache read request, held until i_ready.
- i_ready  out  1  icache request accepted this cycle.
- i_rvalid  out  1  beat for icache.
- i_rdata  out  64  beat data.
- i_raddr  out  32  line address of beat.
- d_addr  in  32  dcache line address.
- d_read  in  1  dcache read request.
- d_write  in  1  dcache write request (mutually exclusive with d_read).
- d_wdata  in  256  write line, sampled on accept.
- d_ready  out  1  dcache request accepted this cycle.
- d_rvalid  out  1  beat for dcache.
- d_rdata  out  64  beat data.
- d_raddr  out  32  line address of beat.
- d_wdone  out  1  one-cycle pulse, write burst complete.
- bmem_addr  out  32  command address.
- bmem_read  out  1  read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  64  write beat.
- bmem_ready  in  1  bmem accepts command/beat this cycle.
- bmem_raddr  in  32  return address.
- bmem_rdata  in  64  return beat.
- bmem_rvalid  in  1  return beat valid.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All outputs 0; bmem_addr/bmem_wdata 0.
  - Queue emptied, beat counters 0, state ARB_IDLE, err cleared.
  - Reset mid-burst abandons the burst; bmem is reset by the same rst_n.
- Issue FSM states: ARB_IDLE, ARB_WRITE.
- ARB_IDLE grant policy: dcache has fixed priority over icache.
  - Reads are eligible only when the queue is not full.
  - Writes are eligible regardless of queue occupancy.
- Read accept (same cycle):
  - bmem_read=1, bmem_addr=requester addr.
  - Accepted iff bmem_ready; xx_ready=1 combinationally.
  - Push {owner, addr} into the queue.
- Write accept:
  - Latch d_wdata/d_addr; drive beat 0 combinationally (bmem_write=1, bmem_wdata=d_wdata[63:0]).
  - If bmem_ready: d_ready=1, go ARB_WRITE with beat=1.
  - Otherwise no accept; retry next cycle.
- ARB_WRITE:
  - Drives bmem_write=1, bmem_addr=latched addr, bmem_wdata=line[64*beat +: 64].
  - Beat advances only on bmem_ready.
  - After beat 3 is accepted: return to ARB_IDLE, d_wdone=1 the next cycle.
  - No reads are issued and no requests are granted in ARB_WRITE.
- Return path:
  - Beat counter 0..3 advances on each bmem_rvalid; beat goes to the owner at queue head.
  - i_/d_rvalid, rdata and raddr are combinational from the bmem inputs (0 latency).
  - On beat 3: pop and wrap the counter to 0.
  - Push and pop in the same cycle is allowed; occupancy is unchanged.
- Errors (err set, sticky until reset):
  - bmem_rvalid with empty queue: beat dropped, no xx_rvalid.
  - bmem_raddr ≠ head addr on beat 0: beat still routed to the head owner.
- Occupancy counter is log2(MAX_OUTSTANDING)+1 bits; read/write pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
- Macro: BMEM_ARB_AGING_EN.
- Defined:
  - A saturating age counter increments each cycle i_read is high and not granted; it clears on icache accept.
  - When age ≥ AGE_LIMIT, icache wins over dcache in ARB_IDLE.
- Undefined: strict dcache priority; no counter logic.

Decomposition:
- Package bmem_arb_pkg:
  - arb_owner_t enum {OWN_I, OWN_D}.
  - arb_state_t enum {ARB_IDLE, ARB_WRITE}.
  - BEAT_W=64, LINE_W=256.
  - arb_tag_t struct {owner, addr}.
- Sub-module arb_tag_fifo: parameterised sync FIFO of arb_tag_t with push/pop/full/empty/head, same clk/rst_n.

Test Plan:
- icache read 0x0000_1000, bmem_ready=1, 4 beats returned 0x11..0x44 -> i_ready pulse; i_rvalid×4 with i_rdata 0x11,0x22,0x33,0x44; i_raddr=0x1000; no d_rvalid.
- i_read and d_read asserted in the same cycle -> d_ready first, i_ready next cycle; beats route D then I in issue order.
- d_write 0x2000, wdata beats A,B,C,D, bmem_ready low on beat 2 for 3 cycles -> beat 2 held stable; d_wdone 1 cycle after beat D accepted; no read issued meanwhile.
- Issue 4 reads with no returns -> 5th read not accepted (ready=0) until first 4th beat pops; d_write still accepted while full.
- bmem_rvalid with empty queue, then raddr mismatch on a later read -> err=1 and stays 1; rst_n=0 for one cycle clears err and queue.
- BMEM_ARB_AGING_EN with d_read held continuously and i_read high -> i_ready asserted after AGE_LIMIT=8 passed-over cycles.
